// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: runtime-loadable truth-table neuron with a streamed config port and a registered lookup.
module lut_neuron_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                load_done,
    output logic                table_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);
    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;
    state_t state, state_n;
    logic [IN_BITS-1:0] waddr, waddr_n;
    logic we, done_n;
    logic [OUT_BITS-1:0] mem [2**IN_BITS];
    assign cfg_ready   = state == LOAD;
    assign table_valid = state == READY;
    assign in_ready    = table_valid;
    always_comb begin
        state_n = state;
        waddr_n = waddr;
        we      = 1'b0;
        done_n  = 1'b0;
        if (cfg_start) begin
            state_n = LOAD;
            waddr_n = '0;
        end else if (state == LOAD && cfg_valid) begin
            we      = 1'b1;
            waddr_n = waddr + 1'b1;
            state_n = waddr == '1 ? READY : LOAD;
            done_n  = waddr == '1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            waddr     <= '0;
            load_done <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            waddr     <= waddr_n;
            load_done <= done_n;
            out_valid <= in_valid && in_ready;
            if (in_valid && in_ready)
                out_data <= mem[in_data];
        end
    end
    // Table RAM carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= cfg_data;
endmodule
